// File: rtl/sobel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: buffers two previous lines and emits
// the full window for every pixel whose 3x3 neighbourhood lies inside the frame.
module sobel_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [7:0]  gray_data,
  output logic        win_valid,
  output logic [71:0] win_data,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col;
  logic          last_row;
  logic          in_run;
  logic          fire;

  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb0_q;
  logic [7:0]    lb1_q;
  logic [7:0]    hist_a  [3];
  logic [7:0]    hist_b  [3];
  logic [7:0]    col_new [3];
  logic [71:0]   win_nxt;

  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));

  // Read-before-write: the column read here is the one from the previous lines.
  assign lb0_q      = lb0[col];
  assign lb1_q      = lb1[col];
  assign col_new[0] = lb0_q;
  assign col_new[1] = lb1_q;
  assign col_new[2] = gray_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (din_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (din_valid && last_col && (row == RW'(1))) begin
          state_nxt = RUN;
        end else begin
          state_nxt = FILL;
        end
      end
      RUN: begin
        if (din_valid && last_col && last_row) begin
          state_nxt = FILL;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_run = 1'b0;
    case (state)
      FILL:    in_run = 1'b0;
      RUN:     in_run = 1'b1;
      default: in_run = 1'b0;
    endcase
  end

  assign fire = din_valid && in_run && (col >= CW'(2));

  // Storage with no reset: FILL rewrites everything before it is used.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      lb0[col] <= lb1_q;
      lb1[col] <= gray_data;
      hist_a   <= hist_b;
      hist_b   <= col_new;
    end
  end

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      win_nxt[8*(3*r)     +: 8] = hist_a[r];
      win_nxt[8*(3*r + 1) +: 8] = hist_b[r];
      win_nxt[8*(3*r + 2) +: 8] = col_new[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_data   <= '0;
    end else begin
      win_valid  <= fire;
      frame_done <= fire && last_col && last_row;
      if (fire) begin
        win_data <= win_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Bench for sobel_window_3x3: three instances of different frame sizes checked
// cycle by cycle against a whole-frame reference model.
module tb_sobel_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [3];
  logic        din_valid  [3];
  logic [7:0]  gray_data  [3];
  logic        win_valid  [3];
  logic [71:0] win_data   [3];
  logic        frame_done [3];

  sobel_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst[0]), .din_valid(din_valid[0]), .gray_data(gray_data[0]),
    .win_valid(win_valid[0]), .win_data(win_data[0]), .frame_done(frame_done[0]));
  sobel_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .clk(clk), .rst(rst[1]), .din_valid(din_valid[1]), .gray_data(gray_data[1]),
    .win_valid(win_valid[1]), .win_data(win_data[1]), .frame_done(frame_done[1]));
  sobel_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(5)) dut_c (
    .clk(clk), .rst(rst[2]), .din_valid(din_valid[2]), .gray_data(gray_data[2]),
    .win_valid(win_valid[2]), .win_data(win_data[2]), .frame_done(frame_done[2]));

  int errors = 0;
  int checks = 0;

  // Reference model: position of the next pixel plus the whole frame sent so far.
  int          mr [3];
  int          mc [3];
  logic [7:0]  img [3][5][5];
  logic [71:0] hold [3];
  logic        exp_v, exp_f, obs_v, obs_f;
  logic [71:0] exp_d, obs_d;

  function automatic int wid(input int d);
    return (d == 1) ? 5 : 4;
  endfunction

  function automatic int hei(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 3 : 5);
  endfunction

  function automatic logic [7:0] px(input logic [71:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  task automatic step(input int d, input bit v, input logic [7:0] pix);
    logic [71:0] w;
    din_valid[d] = v;
    gray_data[d] = pix;
    exp_v = 1'b0;
    exp_f = 1'b0;
    if (v) begin
      img[d][mr[d]][mc[d]] = pix;
      if (mr[d] >= 2 && mc[d] >= 2) begin
        w = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[8*(3*r + c) +: 8] = img[d][mr[d] - 2 + r][mc[d] - 2 + c];
        hold[d] = w;
        exp_v = 1'b1;
        exp_f = (mr[d] == hei(d) - 1) && (mc[d] == wid(d) - 1);
      end
      mc[d] = mc[d] + 1;
      if (mc[d] == wid(d)) begin
        mc[d] = 0;
        mr[d] = (mr[d] + 1 == hei(d)) ? 0 : mr[d] + 1;
      end
    end
    exp_d = hold[d];
    @(posedge clk);
    #1;
    obs_v = win_valid[d];
    obs_d = win_data[d];
    obs_f = frame_done[d];
    din_valid[d] = 1'b0;
  endtask

  task automatic do_reset(input int d, input int n);
    @(negedge clk);
    rst[d]       = 1'b1;
    din_valid[d] = 1'b0;
    mr[d]        = 0;
    mc[d]        = 0;
    hold[d]      = '0;
    #1;
    obs_v = win_valid[d];
    obs_d = win_data[d];
    obs_f = frame_done[d];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      do_reset(d, 2);
      checks++;
      if (obs_v !== 1'b0 || obs_d !== 72'h0 || obs_f !== 1'b0) begin
        errors++;
        $display("FAIL reset_async[%0d]: got v=%b d=%h fd=%b, want all zero", d, obs_v, obs_d, obs_f);
      end
      checks++;
      if (win_valid[d] !== 1'b0 || win_data[d] !== 72'h0 || frame_done[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_held[%0d]: got v=%b d=%h fd=%b, want all zero", d,
                 win_valid[d], win_data[d], frame_done[d]);
      end
      rst[d] = 1'b0;
    end
  endtask

  task automatic test_ramp();
    int nwin = 0;
    logic [71:0] first_w = '0;
    logic [71:0] last_w = '0;
    logic last_f = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1'b1, 8'(16*r + c));
        checks++;
        if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
          errors++;
          $display("FAIL ramp (%0d,%0d): got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                   r, c, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
        end
        if (obs_v === 1'b1) begin
          if (nwin == 0) first_w = obs_d;
          last_w = obs_d;
          last_f = obs_f;
          nwin++;
        end
      end
    end
    checks++;
    if (nwin != 4) begin
      errors++;
      $display("FAIL ramp_count: got %0d windows, want 4", nwin);
    end
    checks++;
    if (px(first_w, 0) !== 8'h00 || px(first_w, 4) !== 8'h11 || px(first_w, 8) !== 8'h22) begin
      errors++;
      $display("FAIL ramp_first: got p0=%h p4=%h p8=%h, want 00 11 22",
               px(first_w, 0), px(first_w, 4), px(first_w, 8));
    end
    checks++;
    if (px(last_w, 0) !== 8'h11 || px(last_w, 8) !== 8'h33 || last_f !== 1'b1) begin
      errors++;
      $display("FAIL ramp_last: got p0=%h p8=%h fd=%b, want 11 33 1",
               px(last_w, 0), px(last_w, 8), last_f);
    end
  endtask

  task automatic test_gappy();
    int nwin = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        for (int g = 0; g < ((c == 3) ? 7 : 2); g++) begin
          step(0, (g == 0), (g == 0) ? 8'(16*r + c) : 8'hA5);
          checks++;
          if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
            errors++;
            $display("FAIL gappy (%0d,%0d) slot %0d: got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                     r, c, g, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
          end
          if (obs_v === 1'b1) nwin++;
        end
      end
    end
    checks++;
    if (nwin != 4) begin
      errors++;
      $display("FAIL gappy_count: got %0d windows, want 4", nwin);
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0;
    int nfd = 0;
    logic [71:0] f2_first = '0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 5; c++) begin
          step(1, 1'b1, (f == 0) ? 8'(8'h40 + 16*r + c) : 8'(16*r + c));
          checks++;
          if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
            errors++;
            $display("FAIL b2b f%0d (%0d,%0d): got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                     f, r, c, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
          end
          if (obs_v === 1'b1) begin
            if (nwin == 3) f2_first = obs_d;
            nwin++;
          end
          if (obs_f === 1'b1) nfd++;
        end
      end
    end
    checks++;
    if (nwin != 6 || nfd != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d windows %0d frame_done, want 6 and 2", nwin, nfd);
    end
    checks++;
    if (px(f2_first, 0) !== 8'h00 || px(f2_first, 8) !== 8'h22) begin
      errors++;
      $display("FAIL b2b_frame2_first: got p0=%h p8=%h, want 00 22", px(f2_first, 0), px(f2_first, 8));
    end
  endtask

  task automatic test_reset_mid();
    int nwin = 0;
    int nfd = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b1, 8'(16*(i/4) + (i%4) + 8'h80));
      checks++;
      if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
        errors++;
        $display("FAIL rstmid_pre px%0d: got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                 i, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
      end
    end
    do_reset(0, 2);
    checks++;
    if (obs_v !== 1'b0 || obs_d !== 72'h0 || obs_f !== 1'b0 ||
        win_valid[0] !== 1'b0 || win_data[0] !== 72'h0 || frame_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b d=%h fd=%b, want all zero", obs_v, obs_d, obs_f);
    end
    rst[0] = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1'b1, 8'(16*r + c));
        checks++;
        if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
          errors++;
          $display("FAIL rstmid_post (%0d,%0d): got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                   r, c, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
        end
        if (obs_v === 1'b1) nwin++;
        if (obs_f === 1'b1) nfd++;
      end
    end
    checks++;
    if (nwin != 4 || nfd != 1) begin
      errors++;
      $display("FAIL rstmid_count: got %0d windows %0d frame_done, want 4 and 1", nwin, nfd);
    end
  endtask

  task automatic test_line_boundary();
    int nwin = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(2, 1'b1, 8'(16*r + c));
        checks++;
        if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
          errors++;
          $display("FAIL lineb (%0d,%0d): got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                   r, c, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
        end
        if (obs_v === 1'b1) begin
          nwin++;
          // Ramp encodes the column in the low nibble: a window spans three adjacent columns.
          checks++;
          if (px(obs_d, 0) + 8'd2 !== px(obs_d, 2) || px(obs_d, 6) + 8'd1 !== px(obs_d, 7)) begin
            errors++;
            $display("FAIL lineb_straddle (%0d,%0d): got p0=%h p2=%h p6=%h p7=%h, want adjacent columns",
                     r, c, px(obs_d, 0), px(obs_d, 2), px(obs_d, 6), px(obs_d, 7));
          end
        end
      end
    end
    checks++;
    if (nwin != 6) begin
      errors++;
      $display("FAIL lineb_count: got %0d windows, want 6", nwin);
    end
  endtask

  task automatic test_random();
    for (int d = 1; d < 3; d++) begin
      int nwin = 0;
      int nfd = 0;
      int sent = 0;
      while (sent < 3 * wid(d) * hei(d)) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        step(d, v, 8'($urandom));
        if (v) sent++;
        checks++;
        if (obs_v !== exp_v || obs_d !== exp_d || obs_f !== exp_f) begin
          errors++;
          $display("FAIL random[%0d] px%0d: got v=%b d=%h fd=%b, want v=%b d=%h fd=%b",
                   d, sent, obs_v, obs_d, obs_f, exp_v, exp_d, exp_f);
        end
        if (obs_v === 1'b1) nwin++;
        if (obs_f === 1'b1) nfd++;
      end
      checks++;
      if (nwin != 3 * (wid(d) - 2) * (hei(d) - 2) || nfd != 3) begin
        errors++;
        $display("FAIL random_count[%0d]: got %0d windows %0d frame_done, want %0d and 3",
                 d, nwin, nfd, 3 * (wid(d) - 2) * (hei(d) - 2));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]       = 1'b1;
      din_valid[d] = 1'b0;
      gray_data[d] = 8'h00;
      mr[d]        = 0;
      mc[d]        = 0;
      hold[d]      = '0;
    end
    test_reset();
    test_ramp();
    test_gappy();
    test_back_to_back();
    test_reset_mid();
    test_line_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
